// File: rtl/vx_issue_stage.sv
// Issue stage: per-warp register scoreboard that holds back RAW/WAW hazards,
// plus a one-entry registered skid to the instruction demux.
module vx_issue_stage #(
  parameter  int NUM_WARPS = 4,
  parameter  int NUM_REGS  = 64,
  parameter  int DATAW     = 128,
  localparam int NW_BITS   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int NR_BITS   = $clog2(NUM_REGS)
) (
  input  logic               clk,
  input  logic               reset,

  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NW_BITS-1:0] in_wid,
  input  logic [NR_BITS-1:0] in_rd,
  input  logic [NR_BITS-1:0] in_rs1,
  input  logic [NR_BITS-1:0] in_rs2,
  input  logic [NR_BITS-1:0] in_rs3,
  input  logic               in_use_rs3,
  input  logic               in_wb,
  input  logic [DATAW-1:0]   in_data,

  output logic               out_valid,
  input  logic               out_ready,
  output logic [NW_BITS-1:0] out_wid,
  output logic [NR_BITS-1:0] out_rd,
  output logic               out_wb,
  output logic [DATAW-1:0]   out_data,

  input  logic               wb_valid,
  input  logic [NW_BITS-1:0] wb_wid,
  input  logic [NR_BITS-1:0] wb_rd,
  input  logic               wb_eop,

  output logic [31:0]        perf_stalls
);

  logic [NUM_WARPS-1:0][NUM_REGS-1:0] pend_q, pend_d;
  logic [NUM_REGS-1:0]                pend_row;

  logic               out_valid_q;
  logic [NW_BITS-1:0] out_wid_q;
  logic [NR_BITS-1:0] out_rd_q;
  logic               out_wb_q;
  logic [DATAW-1:0]   out_data_q;
  logic [31:0]        perf_q;

  logic hazard;
  logic accept;

  // Hazards look only at registered pending state; a writeback landing this
  // cycle releases the waiting instruction on the following cycle.
  assign pend_row = pend_q[in_wid];
  assign hazard   = in_valid & ( pend_row[in_rs1]
                               | pend_row[in_rs2]
                               | (in_use_rs3 & pend_row[in_rs3])
                               | (in_wb      & pend_row[in_rd]) );

  assign in_ready = ~hazard & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    // NOTE: default every combinationally written signal first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    pend_d = pend_q;
    if (wb_valid && wb_eop && (wb_rd != '0)) begin
      pend_d[wb_wid][wb_rd] = 1'b0;
    end
    // Applied after the clear so a set of the same entry wins.
    if (accept && in_wb && (in_rd != '0)) begin
      pend_d[in_wid][in_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the pending array is flop storage that must reset, since stale
      // bits would stall instructions forever; plain payload RAMs need not.
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_wid_q   <= '0;
      out_rd_q    <= '0;
      out_wb_q    <= 1'b0;
      out_data_q  <= '0;
      perf_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order inside this block.
      pend_q <= pend_d;
      if (hazard) begin
        perf_q <= perf_q + 32'd1;
      end
      if (accept) begin
        out_valid_q <= 1'b1;
        out_wid_q   <= in_wid;
        out_rd_q    <= in_rd;
        out_wb_q    <= in_wb;
        out_data_q  <= in_data;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_wid     = out_wid_q;
  assign out_rd      = out_rd_q;
  assign out_wb      = out_wb_q;
  assign out_data    = out_data_q;
  assign perf_stalls = perf_q;

endmodule

// File: tb/tb_vx_issue_stage.sv
// Bench for vx_issue_stage: vector table with hand-derived in_ready, issue
// payloads tracked by a scoreboard queue, plus reset and backpressure sequences.
module tb_vx_issue_stage;

  logic         clk;
  logic         reset;
  logic         in_valid, in_ready;
  logic [1:0]   in_wid;
  logic [5:0]   in_rd, in_rs1, in_rs2, in_rs3;
  logic         in_use_rs3, in_wb;
  logic [127:0] in_data;
  logic         out_valid, out_ready;
  logic [1:0]   out_wid;
  logic [5:0]   out_rd;
  logic         out_wb;
  logic [127:0] out_data;
  logic         wb_valid;
  logic [1:0]   wb_wid;
  logic [5:0]   wb_rd;
  logic         wb_eop;
  logic [31:0]  perf_stalls;

  vx_issue_stage dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_wid      (in_wid),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_rs3      (in_rs3),
    .in_use_rs3  (in_use_rs3),
    .in_wb       (in_wb),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_wid     (out_wid),
    .out_rd      (out_rd),
    .out_wb      (out_wb),
    .out_data    (out_data),
    .wb_valid    (wb_valid),
    .wb_wid      (wb_wid),
    .wb_rd       (wb_rd),
    .wb_eop      (wb_eop),
    .perf_stalls (perf_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [1:0] wid;
    logic [5:0] rd, rs1, rs2, rs3;
    logic       use3, wb, ordy;
    logic       wbv;
    logic [1:0] wbw;
    logic [5:0] wbr;
    logic       eop;
    logic       exp_rdy;
  } vec_t;

  typedef struct {
    logic [1:0]   wid;
    logic [5:0]   rd;
    logic         wb;
    logic [127:0] data;
  } issue_t;

  issue_t sb[$];
  int     n_vec = 0;
  int     n_cmp = 0;
  int     n_err = 0;
  int     exp_stalls = 0;

  function automatic vec_t mkv(input logic vld, input logic [1:0] wid,
                               input logic [5:0] rd, input logic [5:0] rs1,
                               input logic [5:0] rs2, input logic [5:0] rs3,
                               input logic use3, input logic wb,
                               input logic wbv, input logic [1:0] wbw,
                               input logic [5:0] wbr, input logic eop,
                               input logic exp_rdy);
    vec_t v;
    v.vld = vld; v.wid = wid; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.rs3 = rs3;
    v.use3 = use3; v.wb = wb; v.ordy = 1'b1;
    v.wbv = wbv; v.wbw = wbw; v.wbr = wbr; v.eop = eop; v.exp_rdy = exp_rdy;
    return v;
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; drives one cycle of stimulus and advances to the next posedge+1.
  task automatic apply(input vec_t v);
    logic [127:0] d;
    issue_t       e;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_valid = v.vld;  in_wid = v.wid;  in_rd = v.rd;
    in_rs1 = v.rs1;    in_rs2 = v.rs2;  in_rs3 = v.rs3;
    in_use_rs3 = v.use3; in_wb = v.wb;  in_data = d;
    out_ready = v.ordy;
    wb_valid = v.wbv;  wb_wid = v.wbw;  wb_rd = v.wbr;  wb_eop = v.eop;
    #1;
    n_vec++;
    check("in_ready", {159'd0, in_ready}, {159'd0, v.exp_rdy});
    check("out_valid", {159'd0, out_valid}, {159'd0, (sb.size() != 0)});
    if (sb.size() != 0) begin
      check("out_fields", {23'd0, out_wid, out_rd, out_wb, out_data},
            {23'd0, sb[0].wid, sb[0].rd, sb[0].wb, sb[0].data});
      if (v.ordy) void'(sb.pop_front());
    end
    if (v.vld && v.exp_rdy) begin
      e.wid = v.wid; e.rd = v.rd; e.wb = v.wb; e.data = d;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  vec_t held;
  vec_t v;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_wid = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_rs3 = '0;
    in_use_rs3 = 1'b0; in_wb = 1'b0; in_data = '0; out_ready = 1'b1;
    wb_valid = 1'b0; wb_wid = '0; wb_rd = '0; wb_eop = 1'b0;

    #12;
    check("reset out_valid", {159'd0, out_valid}, 160'd0);
    check("reset perf", {128'd0, perf_stalls}, 160'd0);
    check("reset in_ready", {159'd0, in_ready}, 160'd1);
    check("reset out_data", {32'd0, out_data}, 160'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    //              vld wid rd  rs1 rs2 rs3 u3 wb  wbv wbw wbr eop rdy
    tbl.push_back(mkv(1, 0,  5,  1,  2,  0, 0, 1,  0, 0,  0, 0,  1)); // sets [0][5]
    tbl.push_back(mkv(1, 0,  6,  5,  0,  0, 0, 1,  0, 0,  0, 0,  0)); // RAW stall
    tbl.push_back(mkv(1, 0,  6,  5,  0,  0, 0, 1,  1, 0,  5, 1,  0)); // release, still stalled
    tbl.push_back(mkv(1, 0,  6,  5,  0,  0, 0, 1,  0, 0,  0, 0,  1)); // accepted N+1
    tbl.push_back(mkv(1, 1,  7,  0,  0,  0, 0, 1,  0, 0,  0, 0,  1)); // sets [1][7]
    tbl.push_back(mkv(1, 2,  8,  0,  7,  0, 0, 1,  0, 0,  0, 0,  1)); // cross-warp, no stall
    tbl.push_back(mkv(1, 0,  0,  3,  0,  0, 0, 1,  0, 0,  0, 0,  1)); // rd=0 never pends
    tbl.push_back(mkv(1, 0, 10,  0,  0,  0, 0, 0,  0, 0,  0, 0,  1)); // rs1=0 no stall
    tbl.push_back(mkv(1, 3,  9,  1,  1,  0, 0, 1,  0, 0,  0, 0,  1)); // sets [3][9]
    tbl.push_back(mkv(1, 3,  9,  0,  0,  0, 0, 1,  0, 0,  0, 0,  0)); // WAW stall
    tbl.push_back(mkv(1, 3,  9,  0,  0,  0, 0, 1,  1, 3,  9, 0,  0)); // eop=0 leaves pend
    tbl.push_back(mkv(1, 3,  9,  0,  0,  0, 0, 1,  1, 3,  9, 1,  0)); // clear lands next edge
    tbl.push_back(mkv(1, 3,  9,  0,  0,  0, 0, 1,  0, 0,  0, 0,  1));
    tbl.push_back(mkv(1, 1, 11,  0,  0,  7, 0, 1,  0, 0,  0, 0,  1)); // rs3 unused
    tbl.push_back(mkv(1, 1, 12,  0,  0,  7, 1, 1,  0, 0,  0, 0,  0)); // rs3 used -> stall
    tbl.push_back(mkv(0, 1, 12,  0,  0,  7, 1, 1,  0, 0,  0, 0,  1)); // no valid, no hazard
    tbl.push_back(mkv(1, 1,  7,  0,  0,  0, 0, 1,  1, 2,  8, 1,  0)); // WAW [1][7]; clear [2][8]
    tbl.push_back(mkv(1, 2, 13,  8,  0,  0, 0, 1,  1, 1,  7, 1,  1)); // set [2][13] + clear [1][7]
    tbl.push_back(mkv(1, 1,  7,  0,  0,  0, 0, 1,  0, 0,  0, 0,  1)); // [1][7] was cleared
    tbl.push_back(mkv(1, 2, 14, 13,  0,  0, 0, 0,  0, 0,  0, 0,  0)); // [2][13] was set
    tbl.push_back(mkv(0, 0,  0,  0,  0,  0, 0, 0,  1, 0,  0, 1,  1)); // clear of r0 ignored
    tbl.push_back(mkv(0, 0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0,  1));

    foreach (tbl[i]) begin
      if (tbl[i].vld && !tbl[i].exp_rdy) exp_stalls++;
      apply(tbl[i]);
    end
    check("perf after table", {128'd0, perf_stalls}, {128'd0, 32'(exp_stalls)});

    // Reset while an instruction is held by a RAW hazard on [0][5].
    apply(mkv(1, 0, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    held = mkv(1, 0, 20, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    apply(held);
    apply(held);
    in_valid = 1'b1;
    reset = 1'b1;
    #1;
    sb.delete();
    check("async reset out_valid", {159'd0, out_valid}, 160'd0);
    check("async reset perf", {128'd0, perf_stalls}, 160'd0);
    check("async reset in_ready", {159'd0, in_ready}, 160'd1);
    check("async reset out_rd", {154'd0, out_rd}, 160'd0);
    @(posedge clk);
    #1;
    check("no accept in reset", {159'd0, out_valid}, 160'd0);
    reset = 1'b0;
    held.exp_rdy = 1'b1;
    apply(held);
    apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    check("perf after reset", {128'd0, perf_stalls}, 160'd0);

    // Backpressure: output held for three cycles, then drain and accept together.
    apply(mkv(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 3; k++) begin
      v = mkv(1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.ordy = 1'b0;
      apply(v);
    end
    apply(mkv(1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    check("backpressure not a stall", {128'd0, perf_stalls}, 160'd0);
    check("scoreboard drained", {128'd0, 32'(sb.size())}, 160'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vx_issue_stage.md
VX_ISSUE_STAGE -- requirements
Module: VX_issue_stage

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4: warp count; NW_BITS = max(1, clog2(NUM_WARPS)).
REQ-002 SHALL have parameter NUM_REGS, default 64: architectural registers per warp (int + fp); NR_BITS = clog2(NUM_REGS).
REQ-003 SHALL have parameter DATAW, default 128: opaque payload width passed through to the instruction demux.
REQ-004 SHALL have port clk  input  1  clock; one clock domain, all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  decoded instruction present.
REQ-007 SHALL have port in_ready  output  1  instruction accepted this cycle.
REQ-008 SHALL have ports in_wid (NW_BITS), in_rd, in_rs1, in_rs2, in_rs3 (NR_BITS each)  input  instruction warp and register fields.
REQ-009 SHALL have ports in_use_rs3, in_wb  input  1  rs3 operand is read; rd is written.
REQ-010 SHALL have port in_data  input  DATAW  payload.
REQ-011 SHALL have ports out_valid (output 1), out_ready (input 1), out_wid, out_rd, out_wb, out_data (outputs): registered issue interface to the demux.
REQ-012 SHALL have ports wb_valid (1), wb_wid (NW_BITS), wb_rd (NR_BITS), wb_eop (1)  input  writeback commit.
REQ-013 SHALL have port perf_stalls  output  32  count of hazard-stall cycles.

Function
REQ-014 SHALL hold a pending bit array pend[NUM_WARPS][NUM_REGS]; register index 0 SHALL never be set and SHALL never cause a hazard.
REQ-015 hazard SHALL = in_valid AND (pend[wid][rs1] OR pend[wid][rs2] OR (in_use_rs3 AND pend[wid][rs3]) OR (in_wb AND pend[wid][rd])), evaluated only on registered pend state; no same-cycle bypass.
REQ-016 in_ready SHALL = NOT hazard AND (NOT out_valid OR out_ready); in_ready SHALL NOT depend on in_valid other than through hazard.
REQ-017 Accept (in_valid AND in_ready) SHALL load out_wid/rd/wb/data from inputs and set out_valid=1 on the next edge; latency exactly 1 cycle.
REQ-018 Output handshake SHALL sustain one instruction per cycle when out_ready is held high and no hazard exists.
REQ-019 out_valid SHALL clear on out_valid AND out_ready when no accept occurs in the same cycle.
REQ-020 While out_valid AND NOT out_ready, all out_* SHALL remain stable.
REQ-021 On accept with in_wb=1 and in_rd!=0, pend[in_wid][in_rd] SHALL be set on the next edge.
REQ-022 wb_valid AND wb_eop SHALL clear pend[wb_wid][wb_rd] on the next edge; wb_valid with wb_eop=0 SHALL not modify pend.
REQ-023 Clearing an already-clear bit SHALL have no effect; clear of index 0 SHALL be ignored.
REQ-024 Same-cycle set and clear of the same entry is unreachable (REQ-015 WAW check); if it occurs, set SHALL win.
REQ-025 Clear and set of different entries in the same cycle SHALL both take effect.
REQ-026 A stalled instruction released by writeback in cycle N SHALL be accepted no earlier than cycle N+1.
REQ-027 perf_stalls SHALL increment by 1 each cycle hazard=1, wrapping modulo 2^32.

Reset
REQ-028 Asserting reset SHALL immediately clear all pend bits, out_valid, out_wid, out_rd, out_wb, out_data and perf_stalls to 0, including mid-stall or mid-backpressure.
REQ-029 While reset is high, in_ready SHALL be driven only from reset-state values (i.e. 1); no accept or pend update SHALL occur.

Verification
REQ-030 Back-to-back: wid0 rd=5 wb=1, then wid0 rs1=5 -> second stalls; wb_valid/eop wid0 rd5 at cycle N -> second accepted at N+1, perf_stalls counts stall cycles exactly.
REQ-031 Cross-warp: wid1 rd=7 pending, wid2 reads rs2=7 -> no stall, issued next cycle.
REQ-032 Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data stable, in_ready=0; out_ready=1 -> drain and accept same cycle.
REQ-033 r0 and WAW: rd=0 wb=1 then rs1=0 -> no stall; rd=9 twice same warp -> second stalls until rd9 release.
REQ-034 Reset mid-stall: pend[0][5]=1, instruction stalled, reset pulse -> pend cleared, out_valid=0, perf_stalls=0, held instruction accepted next cycle after reset deasserts.
